// File: rtl/gpu_pkg.sv
// Shared state encodings and arithmetic helpers for the GPU block scheduler.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } top_state_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RESET,
    SLOT_ACTIVE
  } slot_state_t;

  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return (num + den - 32'd1) / den;
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// Per-core slot: pulses the core's reset for one cycle between blocks and
// holds core_start while a dispatched block is running.
module dispatch_slot
  import gpu_pkg::*;
#(
  parameter int ID_BITS = 8,
  parameter int TC_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               launch,
  input  logic               kill,
  input  logic               grant,
  input  logic [ID_BITS-1:0] grant_id,
  input  logic [TC_BITS-1:0] grant_tc,
  input  logic               done_ack,
  output slot_state_t        state,
  output logic               core_start,
  output logic               core_reset,
  output logic [ID_BITS-1:0] block_id,
  output logic [TC_BITS-1:0] thread_count
);

  // A kill parks every live slot in SLOT_RESET for one cycle; grants are
  // suppressed afterwards because the scheduler is no longer running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SLOT_IDLE;
      core_start   <= 1'b0;
      core_reset   <= 1'b0;
      block_id     <= '0;
      thread_count <= '0;
    end else begin
      case (state)
        SLOT_IDLE: begin
          if (launch) begin
            state      <= SLOT_RESET;
            core_reset <= 1'b1;
          end
        end
        SLOT_RESET: begin
          if (kill) begin
            core_reset <= 1'b1;
          end else if (grant) begin
            state        <= SLOT_ACTIVE;
            core_reset   <= 1'b0;
            core_start   <= 1'b1;
            block_id     <= grant_id;
            thread_count <= grant_tc;
          end else begin
            state      <= SLOT_IDLE;
            core_reset <= 1'b0;
          end
        end
        SLOT_ACTIVE: begin
          if (kill || done_ack) begin
            state      <= SLOT_RESET;
            core_start <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        default: begin
          state      <= SLOT_IDLE;
          core_start <= 1'b0;
          core_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Splits a kernel into fixed-size thread blocks and hands them out to the
// enabled cores, lowest core index first, until every block has completed.
module block_scheduler
  import gpu_pkg::*;
#(
  parameter int NUM_LOGICAL_CORES = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [THREAD_COUNT_BITS-1:0]                   thread_count,
  input  logic [NUM_LOGICAL_CORES-1:0]                   core_enable,
  input  logic                                           abort,
  input  logic [NUM_LOGICAL_CORES-1:0]                   core_done,
  output logic [NUM_LOGICAL_CORES-1:0]                   core_start,
  output logic [NUM_LOGICAL_CORES-1:0]                   core_reset,
  output logic [NUM_LOGICAL_CORES*THREAD_COUNT_BITS-1:0] core_block_id,
  output logic [NUM_LOGICAL_CORES*TC_BITS-1:0]           core_thread_count,
  output logic                                           done,
  output logic                                           busy,
  output logic [THREAD_COUNT_BITS-1:0]                   blocks_done_count
);

  localparam int NC = NUM_LOGICAL_CORES;
  localparam int W  = THREAD_COUNT_BITS;
  localparam logic [TC_BITS-1:0] FULL_TC = TC_BITS'(THREADS_PER_BLOCK);

  top_state_t           state;
  logic [W-1:0]         thread_q;
  logic [W-1:0]         total_blocks;
  logic [W-1:0]         dispatched;
  logic [NC-1:0]        mask_q;

  logic [W-1:0]         total_calc;
  logic                 launch;
  logic                 kill;
  logic                 dispatch_ok;
  logic [W-1:0]         last_id;
  logic [TC_BITS-1:0]   last_tc;

  slot_state_t          slot_state [NC];
  logic [NC-1:0]        grant;
  logic [NC-1:0]        done_ack;
  logic [W-1:0]         grant_id [NC];
  logic [TC_BITS-1:0]   grant_tc [NC];
  logic [W-1:0]         grant_cnt;
  logic [W-1:0]         done_inc;
  logic [W:0]           next_id;

  assign total_calc  = W'(ceil_div(32'(thread_count), 32'(THREADS_PER_BLOCK)));
  assign launch      = (state == IDLE) && start && (total_calc != '0) && (core_enable != '0);
  assign kill        = (state == RUN) && abort;
  assign dispatch_ok = (state == RUN) && !abort;
  assign last_id     = total_blocks - W'(1);
  assign last_tc     = TC_BITS'(thread_q - (total_blocks - W'(1)) * W'(THREADS_PER_BLOCK));

  // Slots leaving reset in the same cycle take consecutive block IDs in
  // ascending core order; next_id walks forward as each grant is made.
  always_comb begin
    next_id   = {1'b0, dispatched};
    grant     = '0;
    done_ack  = '0;
    grant_cnt = '0;
    done_inc  = '0;
    for (int i = 0; i < NC; i++) begin
      grant_id[i] = '0;
      grant_tc[i] = '0;
      done_ack[i] = dispatch_ok && (slot_state[i] == SLOT_ACTIVE) && core_done[i];
      if (done_ack[i]) begin
        done_inc = done_inc + W'(1);
      end
      if (dispatch_ok && mask_q[i] && (slot_state[i] == SLOT_RESET) &&
          (next_id < {1'b0, total_blocks})) begin
        grant[i]    = 1'b1;
        grant_id[i] = next_id[W-1:0];
        grant_tc[i] = (next_id[W-1:0] == last_id) ? last_tc : FULL_TC;
        next_id     = next_id + (W+1)'(1);
        grant_cnt   = grant_cnt + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      thread_q          <= '0;
      total_blocks      <= '0;
      dispatched        <= '0;
      mask_q            <= '0;
      blocks_done_count <= '0;
      done              <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            thread_q          <= thread_count;
            mask_q            <= core_enable;
            total_blocks      <= total_calc;
            dispatched        <= '0;
            blocks_done_count <= '0;
            if ((total_calc == '0) || (core_enable == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort || (blocks_done_count == total_blocks)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dispatched        <= dispatched + grant_cnt;
            blocks_done_count <= blocks_done_count + done_inc;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NC; g++) begin : g_slot
    dispatch_slot #(
      .ID_BITS(W),
      .TC_BITS(TC_BITS)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .launch      (launch && core_enable[g]),
      .kill        (kill),
      .grant       (grant[g]),
      .grant_id    (grant_id[g]),
      .grant_tc    (grant_tc[g]),
      .done_ack    (done_ack[g]),
      .state       (slot_state[g]),
      .core_start  (core_start[g]),
      .core_reset  (core_reset[g]),
      .block_id    (core_block_id[g*W +: W]),
      .thread_count(core_thread_count[g*TC_BITS +: TC_BITS])
    );
  end

endmodule

// File: doc/block_scheduler.md
BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 Parameter NUM_LOGICAL_CORES, default 2, is the number of logical cores scheduled.
REQ-002 Parameter THREADS_PER_BLOCK, default 4, is the maximum threads per dispatched block.
REQ-003 Parameter THREAD_COUNT_BITS, default 8, is the width of the kernel thread count, block IDs and counters.
REQ-004 Derived TC_BITS = $clog2(THREADS_PER_BLOCK)+1 is the per-core thread-count width.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state rises on posedge.
- reset  in  1  asynchronous, active-low.
- start  in  1  launch request (level), accepted in IDLE.
- thread_count  in  THREAD_COUNT_BITS  kernel thread total, sampled at launch.
- core_enable  in  NUM_LOGICAL_CORES  core mask, sampled at launch.
- abort  in  1  kill the running kernel.
- core_done  in  NUM_LOGICAL_CORES  per-core block complete.
- core_start  out  NUM_LOGICAL_CORES  per-core run, held until done.
- core_reset  out  NUM_LOGICAL_CORES  per-core one-cycle reset pulse.
- core_block_id  out  NUM_LOGICAL_CORES*THREAD_COUNT_BITS  packed; core i at slice i.
- core_thread_count  out  NUM_LOGICAL_CORES*TC_BITS  packed; core i at slice i.
- done  out  1  kernel finished or aborted.
- busy  out  1  high in RUN.
- blocks_done_count  out  THREAD_COUNT_BITS  completed blocks this kernel.

Function
REQ-006 Top FSM SHALL have the states IDLE, RUN and DONE.
REQ-007 In IDLE with start=1, the block SHALL latch thread_count and core_enable and compute total = ceil(thread_count/THREADS_PER_BLOCK).
- If total=0 or the mask is 0, it goes to DONE next cycle and asserts no core_start.
- Otherwise it goes to RUN.
REQ-008 Each core SHALL have a slot FSM: SLOT_IDLE -> SLOT_RESET (core_reset=1, one cycle) -> SLOT_ACTIVE (core_start=1) -> on core_done, SLOT_RESET.
REQ-009 On RUN entry, all enabled slots SHALL enter SLOT_RESET in the same cycle.
REQ-010 A slot leaving SLOT_RESET while dispatched<total SHALL enter SLOT_ACTIVE with the following values, then increment dispatched:
- core_block_id = dispatched.
- core_thread_count = THREADS_PER_BLOCK, except the final block gets thread_count-(total-1)*THREADS_PER_BLOCK (range 1..THREADS_PER_BLOCK).
REQ-011 A slot leaving SLOT_RESET with nothing left to dispatch SHALL go to SLOT_IDLE.
REQ-012 When several slots dispatch in one cycle, the block SHALL grant consecutive IDs in ascending core index.
REQ-013 Latency SHALL be: core_done at cycle t -> core_start low and core_reset high at t+1 -> next block's core_start high at t+2.
REQ-014 core_done from a slot not in SLOT_ACTIVE SHALL be ignored.
REQ-015 Each accepted core_done SHALL increment blocks_done_count by 1; the block SHALL enter DONE in the cycle after blocks_done_count reaches total.
REQ-016 Disabled cores SHALL never see core_start or core_reset asserted.
REQ-017 On abort=1 in RUN:
- All core_start drop next cycle.
- Every slot that was in SLOT_RESET or SLOT_ACTIVE pulses core_reset once.
- The FSM goes to DONE; blocks_done_count freezes.
- core_done in the same cycle as abort is not counted.
REQ-018 abort SHALL be ignored outside RUN.
REQ-019 In DONE, done=1 SHALL be held and core_block_id/core_thread_count SHALL hold their last values.
- DONE returns to IDLE only when start=0; start held high never relaunches.
REQ-020 On DONE->IDLE, done SHALL clear; counters SHALL clear on the next launch.
REQ-021 busy SHALL equal (state==RUN).

Reset
REQ-022 While reset=0, asynchronously:
- All outputs are 0.
- Top FSM is IDLE and all slots are SLOT_IDLE.
- Counters and latched inputs are 0.
REQ-023 Reset asserted mid-RUN SHALL abandon the kernel with no pulses after release; the first launch after release behaves as a fresh kernel.

Structure
REQ-024 Package gpu_pkg SHALL hold the top-state and slot-state enums and a ceil_div function.
REQ-025 The per-core slot FSM SHALL be sub-module dispatch_slot, instantiated NUM_LOGICAL_CORES times.
REQ-026 ID allocation and priority SHALL live in block_scheduler.

Verification (NUM_LOGICAL_CORES=2, THREADS_PER_BLOCK=4)
REQ-027 thread_count=8, mask=2'b11 -> core0 gets block 0 (tc 4) and core1 gets block 1 (tc 4) in the same cycle; after both core_done, done=1 and blocks_done_count=2.
REQ-028 thread_count=10, core1 finishes first -> core1 is reset, then gets block 2 with tc=2 two cycles after its core_done; done after 3 completions.
REQ-029 thread_count=0 -> done=1 one cycle after start; core_start and core_reset stay 0.
REQ-030 mask=2'b10, thread_count=8 -> core1 runs block 0 then block 1 in sequence; core_start[0] and core_reset[0] stay 0 throughout.
REQ-031 thread_count=16, abort while both cores are active -> core_start=00 and core_reset=11 for one cycle; done=1 and blocks_done_count unchanged; a core_done in the abort cycle is not counted.
REQ-032 reset driven low mid-RUN between clock edges -> all outputs 0 immediately; after release, start with thread_count=4 runs block 0 only.
